// File: rtl/serial_mult_arb_pkg.sv
// Shared types and constants for the two-client serial multiplier.
package serial_mult_arb_pkg;

  // Default operand width; the product is twice this.
  localparam int unsigned WIDTH_DEF = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter that walks WIDTH-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_mult_dp.sv
// Shift-add multiply datapath: one partial product per step, LSB of Y first.
module serial_mult_dp
  import serial_mult_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc_nxt_c,
  output logic                 cnteqzero_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    shamt;
  logic [PW-1:0]    addend;
  logic             yzero;

  // Status flags and the accumulator value after the current step.
  always_comb begin
    cnteqzero_c = (cnt == '0);
    yzero       = (y == '0);
    shamt       = CW'(WIDTH - 1) - cnt;
    addend      = PW'(x) << shamt;
    acc_nxt_c   = y[0] ? (acc + addend) : acc;
  end

  // Operand load on grant, then one shift-add per step; acc is left alone once Y is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      x   <= a;
      y   <= b;
      acc <= '0;
      cnt <= CW'(WIDTH - 1);
    end else if (step) begin
      y   <= y >> 1;
      cnt <= cnt - CW'(1);
      if (!yzero) begin
        acc <= acc_nxt_c;
      end
    end
  end

endmodule

// File: rtl/serial_mult_arb.sv
// Two-client round-robin arbiter in front of a serial shift-add multiplier.
module serial_mult_arb
  import serial_mult_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state;
  state_t           state_nxt;
  logic             last_id;
  logic             cur_id;
  logic             gnt_vld_c;
  logic             gnt_id_c;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             op_zero;
  logic             dp_step;
  logic [PW-1:0]    acc_nxt_c;
  logic             cnteqzero_c;

  // Round-robin pick; only IDLE may grant, and never while reset is held.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_id_c  = 1'b0;
    if ((state == IDLE) && !rst) begin
      if (req0 && req1) begin
        gnt_vld_c = 1'b1;
        gnt_id_c  = ~last_id;
      end else if (req0) begin
        gnt_vld_c = 1'b1;
        gnt_id_c  = 1'b0;
      end else if (req1) begin
        gnt_vld_c = 1'b1;
        gnt_id_c  = 1'b1;
      end
    end
  end

  // Operands of the client being granted, and the zero-operand shortcut.
  always_comb begin
    a_sel   = gnt_id_c ? a1 : a0;
    b_sel   = gnt_id_c ? b1 : b0;
    op_zero = (a_sel == '0) || (b_sel == '0);
    dp_step = (state == RUN);
  end

  serial_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (gnt_vld_c),
    .step        (dp_step),
    .a           (a_sel),
    .b           (b_sel),
    .acc_nxt_c   (acc_nxt_c),
    .cnteqzero_c (cnteqzero_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_vld_c) begin
          state_nxt = op_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnteqzero_c) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; grants follow the requests within the IDLE cycle.
  always_comb begin
    gnt0 = gnt_vld_c && !gnt_id_c;
    gnt1 = gnt_vld_c && gnt_id_c;
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Round-robin history and the id of the job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= 1'b1;
      cur_id  <= 1'b0;
    end else if (gnt_vld_c) begin
      last_id <= gnt_id_c;
      cur_id  <= gnt_id_c;
    end
  end

  // Result registers load on the edge entering DONE and hold until the next job finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      done_id <= 1'b0;
    end else if ((state == IDLE) && (state_nxt == DONE)) begin
      product <= '0;
      done_id <= gnt_id_c;
    end else if ((state == RUN) && (state_nxt == DONE)) begin
      product <= acc_nxt_c;
      done_id <= cur_id;
    end
  end

endmodule

// File: tb/tb_serial_mult_arb.sv
// Directed bench for serial_mult_arb at WIDTH=8.
module tb_serial_mult_arb;

  logic        clk;
  logic        rst;
  logic        req0;
  logic [7:0]  a0;
  logic [7:0]  b0;
  logic        req1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic        done;
  logic        done_id;
  logic [15:0] product;

  int pass_cnt;
  int total_cnt;
  int viol;

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs [8];

  serial_mult_arb #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol watch: exclusive grants, no grant outside IDLE, quiet outputs under reset.
  always @(negedge clk) begin
    if ((gnt0 && gnt1) || ((gnt0 || gnt1) && (busy || rst)) || (rst && (done || busy)))
      viol <= viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Called right after the grant edge; counts cycles until done (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  // One full job from IDLE: request, grant, latency, result, return to IDLE.
  task automatic run_job(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] ep, input int elat, input string nm);
    int lat;
    if (id == 1'b0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else            begin req1 = 1'b1; a1 = a; b1 = b; end
    #1;
    check({nm, " gnt"}, 32'({gnt1, gnt0}), id ? 32'd2 : 32'd1);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(lat);
    check({nm, " latency"}, 32'(lat), 32'(elat));
    check({nm, " product"}, 32'(product), 32'(ep));
    check({nm, " done_id"}, 32'(done_id), 32'(id));
    tick();
    check({nm, " done pulse/idle"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int lat;
    pass_cnt  = 0;
    total_cnt = 0;
    viol      = 0;
    rst  = 1'b1;
    req0 = 1'b0; a0 = '0; b0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'd143,   9, "13x11"};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 16'd65025, 9, "255x255"};
    vecs[2] = '{1'b1, 8'd0,   8'd77,  16'd0,     1, "0x77 c1"};
    vecs[3] = '{1'b0, 8'd77,  8'd0,   16'd0,     1, "77x0 c0"};
    vecs[4] = '{1'b1, 8'd1,   8'd1,   16'd1,     9, "1x1"};
    vecs[5] = '{1'b1, 8'd128, 8'd2,   16'd256,   9, "128x2"};
    vecs[6] = '{1'b0, 8'd255, 8'd1,   16'd255,   9, "255x1"};
    vecs[7] = '{1'b1, 8'd170, 8'd85,  16'd14450, 9, "170x85"};

    // Reset state, with a request pending that must not be granted.
    tick(); tick();
    req0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
    #1;
    check("reset gnt", 32'({gnt1, gnt0}), 32'd0);
    check("reset busy/done", 32'({busy, done}), 32'd0);
    check("reset product", 32'(product), 32'd0);
    check("reset done_id", 32'(done_id), 32'd0);
    req0 = 1'b0;
    tick();
    rst = 1'b0;

    // Tie straight after reset: client 0 first, then client 1.
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
    req1 = 1'b1; a1 = 8'd7; b1 = 8'd9;
    #1;
    check("tie first gnt", 32'({gnt1, gnt0}), 32'd1);
    tick();
    req0 = 1'b0;
    wait_done(lat);
    check("tie job0 latency", 32'(lat), 32'd9);
    check("tie job0 product", 32'(product), 32'd15);
    check("tie job0 done_id", 32'(done_id), 32'd0);
    tick();
    check("tie second gnt", 32'({gnt1, gnt0}), 32'd2);
    tick();
    req1 = 1'b0;
    wait_done(lat);
    check("tie job1 product", 32'(product), 32'd63);
    check("tie job1 done_id", 32'(done_id), 32'd1);
    tick();

    // Fairness: both requests held across four jobs.
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd3;
    req1 = 1'b1; a1 = 8'd4; b1 = 8'd5;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("fair%0d gnt", k), 32'({gnt1, gnt0}), (k % 2 == 1) ? 32'd2 : 32'd1);
      tick();
      wait_done(lat);
      check($sformatf("fair%0d product", k), 32'(product), (k % 2 == 1) ? 32'd20 : 32'd6);
      check($sformatf("fair%0d done_id", k), 32'(done_id), 32'(k % 2));
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, vecs[i].name);
    end

    // Reset four cycles into RUN aborts the job; a fresh job then completes.
    req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
    #1;
    check("abort gnt", 32'({gnt1, gnt0}), 32'd1);
    tick();
    req0 = 1'b0;
    tick(); tick(); tick();
    check("abort in RUN", 32'({busy, done}), 32'd2);
    rst = 1'b1;
    #1;
    check("abort busy/done", 32'({busy, done}), 32'd0);
    check("abort product", 32'(product), 32'd0);
    check("abort done_id", 32'(done_id), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post-abort no done", 32'({busy, done}), 32'd0);
    run_job(1'b0, 8'd2, 8'd2, 16'd4, 9, "post-abort 2x2");

    tick();
    check("protocol violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_mult_arb.md
SERIAL_MULT_ARB -- requirements
Module: serial_mult_arb

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; product width is 2*WIDTH.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0  input  1  client 0 request; held high until gnt0.
REQ-006 a0, b0  input  WIDTH each  client 0 unsigned operands; valid while req0=1.
REQ-007 req1  input  1  client 1 request; held high until gnt1.
REQ-008 a1, b1  input  WIDTH each  client 1 unsigned operands; valid while req1=1.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured on the same rising edge.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; product valid.
REQ-012 done_id  output  1  client served by the current done; held until the next done.
REQ-013 product  output  2*WIDTH  unsigned a*b; held until the next done.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; the encoding is internal.
REQ-015 In IDLE, if any req is high, the block SHALL assert exactly one gnt combinationally and leave IDLE on the next edge.
REQ-016 Arbitration SHALL be round-robin: if both req are high, grant the client not equal to last_id; if one is high, grant it; last_id updates on each grant.
REQ-017 On the grant edge: X=a, Y=b, acc=0, cnt=WIDTH-1, and the served id is latched.
REQ-018 IDLE->RUN SHALL occur on the grant edge when both operands are nonzero; IDLE->DONE when either is zero (acc stays 0).
REQ-019 RUN SHALL execute one shift-add step per cycle: if Y[0], acc+=X<<(WIDTH-1-cnt) in 2*WIDTH arithmetic with no truncation; Y>>=1; cnt-=1.
REQ-020 RUN->DONE SHALL occur on the edge where cnt==0 is processed; RUN lasts exactly WIDTH cycles regardless of operand values.
REQ-021 In DONE, done=1, and product and done_id SHALL update on entry; DONE->IDLE is unconditional after one cycle.
REQ-022 Latency: done is high WIDTH+1 cycles after the grant cycle (nonzero operands), or 1 cycle after (zero operand).
REQ-023 Requests seen in RUN/DONE SHALL NOT be granted; earliest re-grant is the IDLE cycle after DONE (min 1 idle cycle between jobs).
REQ-024 A request dropped before its grant SHALL be treated as withdrawn; no error is flagged.
REQ-025 gnt0 and gnt1 SHALL never be high together; gnt SHALL only be high in IDLE.

Reset
REQ-026 While rst=1: state=IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, product=0, acc=0, cnt=0, last_id=1, so client 0 wins the first tie.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort the job with no done pulse; after release the block accepts new requests from IDLE.

Structure
REQ-028 A shared package SHALL hold the state typedef (IDLE/RUN/DONE) and the WIDTH default constant.
REQ-029 The shift-add datapath (X, Y, acc, cnt, cnteqzero/yzero status) SHALL be the sub-module serial_mult_dp; serial_mult_arb holds the FSM, arbiter, and output registers.

Verification (WIDTH=8)
REQ-030 Single job: req0=1, a0=13, b0=11 -> gnt0 pulse at cycle t, done at t+9, product=143, done_id=0.
REQ-031 Tie after reset: req0=req1=1 (0: 3*5, 1: 7*9) -> client 0 served first (product=15, id 0), then client 1 (product=63, id 1).
REQ-032 Max operands: 255*255 -> product=65025, no overflow.
REQ-033 Zero shortcut: a1=0, b1=77 -> done one cycle after gnt1, product=0, done_id=1.
REQ-034 Reset mid-RUN: assert rst 4 cycles after a grant -> no done, all outputs 0; a new job of 2*2 afterwards completes with product=4.
REQ-035 Fairness: both req held high for 4 jobs -> grants alternate 0,1,0,1; gnt0 and gnt1 never high together.
